// File: rtl/particle_sim_engine.sv
// Serial sand-grain simulator: one grain evaluated per cycle under selectable 8-way gravity,
// with runtime spawn/clear and a continuous raster scan that emits coloured pixel writes.
module particle_sim_engine #(
  parameter int GRID_W        = 64,
  parameter int GRID_H        = 64,
  parameter int COORD_W       = 6,
  parameter int NUM_PARTICLES = 16,
  parameter int UPDATE_PERIOD = 262144,
  parameter int WRITE_DIV     = 16,
  parameter int COLOR_W       = 12,
  parameter logic [COLOR_W-1:0] SAND_COLOR   = 12'hFF0,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = 12'hFFF,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         direction,
  input  logic                               pause,
  input  logic                               slide_en,
  input  logic                               clear,
  input  logic                               spawn_valid,
  input  logic [COORD_W-1:0]                 spawn_x,
  input  logic [COORD_W-1:0]                 spawn_y,
  output logic                               spawn_ready,
  output logic                               spawn_reject,
  output logic                               busy,
  output logic [$clog2(NUM_PARTICLES+1)-1:0] active_count,
  output logic                               write_en,
  output logic [COORD_W-1:0]                 write_x,
  output logic [COORD_W-1:0]                 write_y,
  output logic [COLOR_W-1:0]                 pixel_color,
  output logic                               frame_done
);

  localparam int CNT_W  = $clog2(NUM_PARTICLES + 1);
  localparam int IDX_W  = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1;
  localparam int TICK_W = $clog2(UPDATE_PERIOD);
  localparam int DIV_W  = (WRITE_DIV > 1) ? $clog2(WRITE_DIV) : 1;
  localparam int SW     = COORD_W + 1;

  typedef enum logic {IDLE, SWEEP} state_t;
  typedef logic signed [SW-1:0] scoord_t;

  localparam scoord_t S_Z  = scoord_t'(0);
  localparam scoord_t S_P1 = scoord_t'(1);
  localparam scoord_t S_M1 = scoord_t'(-1);

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  logic                 flip;
  logic [TICK_W-1:0]    tick;
  logic                 tick_wrap;
  logic [NUM_PARTICLES-1:0] active;
  logic [COORD_W-1:0]   pos_x [NUM_PARTICLES];
  logic [COORD_W-1:0]   pos_y [NUM_PARTICLES];

  function automatic logic is_interior(input scoord_t x, input scoord_t y);
    return (x >= S_P1) && (x <= scoord_t'(GRID_W - 2)) &&
           (y >= S_P1) && (y <= scoord_t'(GRID_H - 2));
  endfunction

  assign tick_wrap = !pause && (tick == TICK_W'(UPDATE_PERIOD - 1));
  assign busy      = (state == SWEEP);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (tick_wrap) state_next = SWEEP;
        SWEEP:   if (idx == IDX_W'(NUM_PARTICLES - 1)) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- Per-slot move evaluation ----------------
  scoord_t          dx, dy, a1x, a1y, a2x, a2y, swp_x, swp_y, cur_x, cur_y;
  scoord_t          t_x [3];
  scoord_t          t_y [3];
  logic [2:0]       legal;
  logic             move;
  logic [COORD_W-1:0] new_x, new_y;

  always_comb begin
    dx = S_Z;
    dy = S_Z;
    case (direction)
      3'd0: begin dx = S_Z;  dy = S_P1; end
      3'd1: begin dx = S_M1; dy = S_P1; end
      3'd2: begin dx = S_M1; dy = S_Z;  end
      3'd3: begin dx = S_M1; dy = S_M1; end
      3'd4: begin dx = S_Z;  dy = S_M1; end
      3'd5: begin dx = S_P1; dy = S_M1; end
      3'd6: begin dx = S_P1; dy = S_Z;  end
      default: begin dx = S_P1; dy = S_P1; end
    endcase

    if (dx != S_Z && dy != S_Z) begin
      a1x = dx;  a1y = S_Z;
      a2x = S_Z; a2y = dy;
    end else if (dx == S_Z) begin
      a1x = S_P1; a1y = dy;
      a2x = S_M1; a2y = dy;
    end else begin
      a1x = dx; a1y = S_P1;
      a2x = dx; a2y = S_M1;
    end
    // Alternating the side preference on cardinal moves keeps piles symmetric over time.
    swp_x = a1x;
    swp_y = a1y;
    if (flip && (dx == S_Z || dy == S_Z)) begin
      a1x = a2x;   a1y = a2y;
      a2x = swp_x; a2y = swp_y;
    end

    cur_x  = scoord_t'({1'b0, pos_x[idx]});
    cur_y  = scoord_t'({1'b0, pos_y[idx]});
    t_x[0] = cur_x + dx;  t_y[0] = cur_y + dy;
    t_x[1] = cur_x + a1x; t_y[1] = cur_y + a1y;
    t_x[2] = cur_x + a2x; t_y[2] = cur_y + a2y;

    for (int k = 0; k < 3; k++) begin
      legal[k] = is_interior(t_x[k], t_y[k]);
      for (int j = 0; j < NUM_PARTICLES; j++) begin
        if (active[j] && (IDX_W'(j) != idx) &&
            scoord_t'({1'b0, pos_x[j]}) == t_x[k] &&
            scoord_t'({1'b0, pos_y[j]}) == t_y[k])
          legal[k] = 1'b0;
      end
    end

    move  = 1'b1;
    new_x = t_x[0][COORD_W-1:0];
    new_y = t_y[0][COORD_W-1:0];
    if (!legal[0]) begin
      if (slide_en && legal[1]) begin
        new_x = t_x[1][COORD_W-1:0];
        new_y = t_y[1][COORD_W-1:0];
      end else if (slide_en && legal[2]) begin
        new_x = t_x[2][COORD_W-1:0];
        new_y = t_y[2][COORD_W-1:0];
      end else begin
        move = 1'b0;
      end
    end
  end

  // ---------------- Spawn ----------------
  logic             spawn_hit, spawn_legal, spawn_take;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    spawn_hit = 1'b0;
    free_idx  = '0;
    for (int j = NUM_PARTICLES - 1; j >= 0; j--) begin
      if (!active[j]) free_idx = IDX_W'(j);
      if (active[j] && pos_x[j] == spawn_x && pos_y[j] == spawn_y) spawn_hit = 1'b1;
    end
  end

  assign spawn_ready = (state == IDLE) && (active_count < CNT_W'(NUM_PARTICLES)) && !clear;
  assign spawn_legal = !spawn_hit &&
                       is_interior(scoord_t'({1'b0, spawn_x}), scoord_t'({1'b0, spawn_y}));
  assign spawn_take  = spawn_valid && spawn_ready && spawn_legal;

  // ---------------- Control state ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      active       <= '0;
      active_count <= '0;
      tick         <= '0;
      idx          <= '0;
      flip         <= 1'b0;
      spawn_reject <= 1'b0;
    end else begin
      spawn_reject <= 1'b0;
      if (!pause) tick <= tick_wrap ? '0 : tick + TICK_W'(1);

      if (clear) begin
        active       <= '0;
        active_count <= '0;
        idx          <= '0;
      end else if (state == IDLE) begin
        idx <= '0;
        if (spawn_valid && spawn_ready) begin
          if (spawn_legal) begin
            active[free_idx] <= 1'b1;
            active_count     <= active_count + CNT_W'(1);
          end else begin
            spawn_reject <= 1'b1;
          end
        end
      end else begin
        if (idx == IDX_W'(NUM_PARTICLES - 1)) begin
          idx  <= '0;
          flip <= ~flip;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // NOTE: positions carry no reset; a slot's coordinates are meaningless until its active bit is set.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      if (spawn_take) begin
        pos_x[free_idx] <= spawn_x;
        pos_y[free_idx] <= spawn_y;
      end else if (state == SWEEP && active[idx] && move) begin
        pos_x[idx] <= new_x;
        pos_y[idx] <= new_y;
      end
    end
  end

  // ---------------- Raster scan ----------------
  logic [DIV_W-1:0]   div;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               scan_grain, scan_border, scan_last;
  logic [COLOR_W-1:0] scan_color;

  always_comb begin
    scan_grain = 1'b0;
    for (int j = 0; j < NUM_PARTICLES; j++)
      if (active[j] && pos_x[j] == scan_x && pos_y[j] == scan_y) scan_grain = 1'b1;
    scan_border = (scan_x == '0) || (scan_x == COORD_W'(GRID_W - 1)) ||
                  (scan_y == '0) || (scan_y == COORD_W'(GRID_H - 1));
    scan_last   = (scan_x == COORD_W'(GRID_W - 1)) && (scan_y == COORD_W'(GRID_H - 1));
    if (scan_border)     scan_color = BORDER_COLOR;
    else if (scan_grain) scan_color = SAND_COLOR;
    else                 scan_color = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      write_en    <= 1'b0;
      write_x     <= '0;
      write_y     <= '0;
      pixel_color <= BG_COLOR;
      frame_done  <= 1'b0;
    end else begin
      div        <= (div == DIV_W'(WRITE_DIV - 1)) ? '0 : div + DIV_W'(1);
      write_en   <= (div == '0);
      frame_done <= 1'b0;
      if (div == '0) begin
        write_x     <= scan_x;
        write_y     <= scan_y;
        pixel_color <= scan_color;
        frame_done  <= scan_last;
        if (scan_x == COORD_W'(GRID_W - 1)) begin
          scan_x <= '0;
          scan_y <= (scan_y == COORD_W'(GRID_H - 1)) ? '0 : scan_y + COORD_W'(1);
        end else begin
          scan_x <= scan_x + COORD_W'(1);
        end
      end
    end
  end

endmodule
